// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button debouncer.
package button_pkg;

    // Default filter length: 20 ms at 100 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 2_000_000;

    // Debounce FSM states; WAIT_* hold a candidate level until it has been stable long enough.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } state_e;

endpackage : button_pkg

// File: rtl/button_sync2.sv
// Two-flop synchronizer bringing the raw button level into the clk domain.
module button_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : button_sync2

// File: rtl/button_debounce.sv
// Push-button debouncer: four-state filter FSM with registered level and edge pulses.
// Optional build macro: BUTTON_SYNC_EN inserts a two-flop synchronizer ahead of the FSM
// (adds two cycles of latency); without it the input must already be synchronous to clk.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy_input,
    output logic debounced_output,
    output logic p_edge,
    output logic n_edge,
    output logic any_edge
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic sample;

`ifdef BUTTON_SYNC_EN
    button_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (noisy_input),
        .q_o   (sample)
    );
`else
    assign sample = noisy_input;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             debounced_q, debounced_d;
    logic             p_edge_q, p_edge_d;
    logic             n_edge_q, n_edge_d;
    logic             any_edge_q, any_edge_d;

    // State, counter and output registers; reset returns to a quiet low level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= STABLE_LOW;
            cnt_q       <= '0;
            debounced_q <= 1'b0;
            p_edge_q    <= 1'b0;
            n_edge_q    <= 1'b0;
            any_edge_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            debounced_q <= debounced_d;
            p_edge_q    <= p_edge_d;
            n_edge_q    <= n_edge_d;
            any_edge_q  <= any_edge_d;
        end
    end

    // Next-state, counter and output decode; any disagreeing sample drops back to the stable state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        p_edge_d    = 1'b0;
        n_edge_d    = 1'b0;
        debounced_d = 1'b0;
        any_edge_d  = 1'b0;

        case (state_q)
            STABLE_LOW: begin
                if (sample) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!sample) begin
                    state_d = STABLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = STABLE_HIGH;
                    p_edge_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sample) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (sample) begin
                    state_d = STABLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = STABLE_LOW;
                    n_edge_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
            end
        endcase

        debounced_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
        any_edge_d  = p_edge_d | n_edge_d;
    end

    assign debounced_output = debounced_q;
    assign p_edge           = p_edge_q;
    assign n_edge           = n_edge_q;
    assign any_edge         = any_edge_q;

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a short filter (8 cycles).
module tb_button_debounce;

    localparam int unsigned DEB = 8;
`ifdef BUTTON_SYNC_EN
    localparam int unsigned SYNC_LAT = 2;
`else
    localparam int unsigned SYNC_LAT = 0;
`endif
    // Edges from the first edge seeing a new level to the output change.
    localparam int unsigned LAT = DEB + SYNC_LAT;

    logic clk = 1'b0;
    logic reset;
    logic noisy_input;
    logic debounced_output;
    logic p_edge;
    logic n_edge;
    logic any_edge;

    int errors = 0;
    int checks = 0;
    int p_cnt, n_cnt, any_cnt;
    int both_cnt = 0;
    int any_bad = 0;

    button_debounce #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk              (clk),
        .reset            (reset),
        .noisy_input      (noisy_input),
        .debounced_output (debounced_output),
        .p_edge           (p_edge),
        .n_edge           (n_edge),
        .any_edge         (any_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then sample outputs 1 ns later and tally pulses.
    task automatic step();
        @(posedge clk);
        #1;
        p_cnt   += int'(p_edge === 1'b1);
        n_cnt   += int'(n_edge === 1'b1);
        any_cnt += int'(any_edge === 1'b1);
        if (p_edge === 1'b1 && n_edge === 1'b1) both_cnt++;
        if (any_edge !== (p_edge | n_edge)) any_bad++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        p_cnt = 0; n_cnt = 0; any_cnt = 0;
    endtask

    function automatic logic [31:0] outs();
        return 32'({debounced_output, p_edge, n_edge, any_edge});
    endfunction

    initial begin
        reset = 1'b1;
        noisy_input = 1'b1;
        clr();

        // Reset held three edges with the button pressed: everything quiet.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outs", outs(), 32'h0);
        end
        reset = 1'b0;
        clr();

        // Rise after exactly LAT edges from reset release, one p_edge pulse.
        steps(int'(LAT) - 1);
        check("rst_rise_early", outs(), 32'h0);
        step();
        check("rst_rise", outs(), 32'b1101);
        step();
        check("rst_rise_after", outs(), 32'b1000);
        check("rst_rise_pcnt", 32'(p_cnt), 32'd1);

        // Release: falls LAT edges after the input drops, one n_edge, no p_edge.
        noisy_input = 1'b0;
        clr();
        steps(int'(LAT) - 1);
        check("rel_early", outs(), 32'b1000);
        step();
        check("rel_fall", outs(), 32'b0011);
        step();
        check("rel_after", outs(), 32'h0);
        check("rel_ncnt", 32'(n_cnt), 32'd1);
        check("rel_pcnt", 32'(p_cnt), 32'd0);

        // Glitch rejection: 7-cycle highs separated by 7-cycle lows never get through.
        clr();
        for (int k = 0; k < 5; k++) begin
            noisy_input = 1'b1;
            steps(7);
            noisy_input = 1'b0;
            steps(7);
            check("glitch_level", 32'(debounced_output), 32'd0);
        end
        steps(int'(LAT) + 2);
        check("glitch_level_end", 32'(debounced_output), 32'd0);
        check("glitch_pulses", 32'(any_cnt), 32'd0);

        // Bounce: five toggles three cycles apart ending high, then held.
        clr();
        for (int k = 0; k < 5; k++) begin
            noisy_input = (k % 2 == 0);
            if (k < 4) steps(3);
        end
        steps(int'(LAT) - 1);
        check("bounce_early", outs(), 32'h0);
        step();
        check("bounce_rise", outs(), 32'b1101);
        steps(20 - int'(LAT));
        check("bounce_held", outs(), 32'b1000);
        check("bounce_pcnt", 32'(p_cnt), 32'd1);
        check("bounce_ncnt", 32'(n_cnt), 32'd0);

        // Short low glitch while high is rejected too.
        clr();
        noisy_input = 1'b0;
        steps(DEB - 1);
        noisy_input = 1'b1;
        steps(int'(LAT) + 2);
        check("low_glitch_level", 32'(debounced_output), 32'd1);
        check("low_glitch_pulses", 32'(any_cnt), 32'd0);

        // Go low, then reset in the middle of a press: progress is discarded.
        noisy_input = 1'b0;
        steps(int'(LAT) + 2);
        check("pre_mid_low", 32'(debounced_output), 32'd0);
        clr();
        noisy_input = 1'b1;
        steps(5);
        reset = 1'b1;
        step();
        check("mid_reset_outs", outs(), 32'h0);
        reset = 1'b0;
        steps(int'(LAT) - 1);
        check("mid_reset_early", outs(), 32'h0);
        step();
        check("mid_reset_rise", outs(), 32'b1101);
        check("mid_reset_pcnt", 32'(p_cnt), 32'd1);

        // Reset while stable high produces no falling pulse.
        clr();
        reset = 1'b1;
        step();
        check("reset_from_high", outs(), 32'h0);
        reset = 1'b0;
        noisy_input = 1'b0;
        steps(int'(LAT) + 2);
        check("reset_from_high_pulses", 32'(any_cnt), 32'd0);

        check("never_both_edges", 32'(both_cnt), 32'd0);
        check("any_edge_is_or", 32'(any_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_button_debounce
